// File: rtl/def.sv
// Shared decode definitions: opcode/funct constants and the control bundle
// handed from the decode stage to the ALU.
package def;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      logic        add;
      logic        sub;
      logic        and_;
      logic        or_;
      logic        xor_;
      logic        sll;
      logic        srl;
      logic        sra;
      logic        slt;
      logic        sltu;
      logic        is_imm;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        illegal;
   } control_info;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 integer register file: two write-first combinational read ports,
// one synchronous write port, synchronous clear. x0 is hardwired to zero.
module regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] mem [32];

   // Storage update: clear on reset, otherwise write any register except x0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (we && (wa != 5'd0)) begin
         mem[wa] <= wd;
      end
   end

   // Read ports: x0 reads zero, a same-cycle write to the read index wins.
   always_comb begin
      rd1 = 32'd0;
      rd2 = 32'd0;
      if (ra1 == 5'd0) begin
         rd1 = 32'd0;
      end else if (we && (wa == ra1)) begin
         rd1 = wd;
      end else begin
         rd1 = mem[ra1];
      end
      if (ra2 == 5'd0) begin
         rd2 = 32'd0;
      end else if (we && (wa == ra2)) begin
         rd2 = wd;
      end else begin
         rd2 = mem[ra2];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM decode stage: decodes one instruction per accept, reads
// its operands and holds them in a single output slot that keeps tracking
// writeback updates while the ALU stalls.
module decode_stage
   import def::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_INSTR,
   input  logic        FLUSH,
   input  logic        WB_WE,
   input  logic [4:0]  WB_RD,
   input  logic [31:0] WB_VAL,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output control_info CTR_INFO,
   output logic [31:0] RS1_VAL,
   output logic [31:0] RS2_VAL
);

   // Illegal encodings collapse to a bundle with only 'illegal' set.
   function automatic control_info decode_instr(input logic [31:0] instr);
      control_info c;
      logic        legal;
      logic [6:0]  f7;
      logic [2:0]  f3;
      c     = '0;
      legal = 1'b1;
      f7    = instr[31:25];
      f3    = instr[14:12];
      case (instr[6:0])
         OPC_OP: begin
            case (f3)
               F3_ADD_SUB: begin
                  if (f7 == F7_BASE)     c.add = 1'b1;
                  else if (f7 == F7_ALT) c.sub = 1'b1;
                  else                   legal = 1'b0;
               end
               F3_SRL_SRA: begin
                  if (f7 == F7_BASE)     c.srl = 1'b1;
                  else if (f7 == F7_ALT) c.sra = 1'b1;
                  else                   legal = 1'b0;
               end
               default: begin
                  if (f7 == F7_BASE) begin
                     case (f3)
                        F3_SLL:  c.sll  = 1'b1;
                        F3_SLT:  c.slt  = 1'b1;
                        F3_SLTU: c.sltu = 1'b1;
                        F3_XOR:  c.xor_ = 1'b1;
                        F3_OR:   c.or_  = 1'b1;
                        F3_AND:  c.and_ = 1'b1;
                        default: legal  = 1'b0;
                     endcase
                  end else begin
                     legal = 1'b0;
                  end
               end
            endcase
         end
         OPC_OP_IMM: begin
            c.is_imm = 1'b1;
            c.imm    = {{20{instr[31]}}, instr[31:20]};
            case (f3)
               F3_ADD_SUB: c.add  = 1'b1;
               F3_SLT:     c.slt  = 1'b1;
               F3_SLTU:    c.sltu = 1'b1;
               F3_XOR:     c.xor_ = 1'b1;
               F3_OR:      c.or_  = 1'b1;
               F3_AND:     c.and_ = 1'b1;
               F3_SLL: begin
                  c.imm = {27'd0, instr[24:20]};
                  if (f7 == F7_BASE) c.sll = 1'b1;
                  else               legal = 1'b0;
               end
               F3_SRL_SRA: begin
                  c.imm = {27'd0, instr[24:20]};
                  if (f7 == F7_BASE)     c.srl = 1'b1;
                  else if (f7 == F7_ALT) c.sra = 1'b1;
                  else                   legal = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      if (legal) begin
         c.rd    = instr[11:7];
         c.rd_we = (instr[11:7] != 5'd0);
      end else begin
         c         = '0;
         c.illegal = 1'b1;
      end
      return c;
   endfunction

   control_info dec;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [31:0] rf_rs1;
   logic [31:0] rf_rs2;
   logic [4:0]  slot_rs1;
   logic [4:0]  slot_rs2;
   logic        accept;

   // The slot can take a new instruction when empty or being drained.
   assign IN_READY = !OUT_VALID || OUT_READY;
   assign accept   = IN_VALID && IN_READY;

   // Decode and operand index selection; unused operands point at x0 so
   // they read zero and never match a writeback snoop.
   always_comb begin
      dec     = decode_instr(IN_INSTR);
      rs1_idx = 5'd0;
      rs2_idx = 5'd0;
      if (dec.illegal) begin
         rs1_idx = 5'd0;
         rs2_idx = 5'd0;
      end else if (dec.is_imm) begin
         rs1_idx = IN_INSTR[19:15];
         rs2_idx = 5'd0;
      end else begin
         rs1_idx = IN_INSTR[19:15];
         rs2_idx = IN_INSTR[24:20];
      end
   end

   regfile u_regfile (
      .clk (CLK),
      .rst (RST),
      .we  (WB_WE),
      .wa  (WB_RD),
      .wd  (WB_VAL),
      .ra1 (rs1_idx),
      .ra2 (rs2_idx),
      .rd1 (rf_rs1),
      .rd2 (rf_rs2)
   );

   // Output slot: reset > flush > accept; otherwise drain on consume and
   // refresh held operands from writeback so they never go stale.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         CTR_INFO  <= '0;
         RS1_VAL   <= 32'd0;
         RS2_VAL   <= 32'd0;
         slot_rs1  <= 5'd0;
         slot_rs2  <= 5'd0;
      end else if (FLUSH) begin
         OUT_VALID <= 1'b0;
      end else if (accept) begin
         OUT_VALID <= 1'b1;
         CTR_INFO  <= dec;
         RS1_VAL   <= rf_rs1;
         RS2_VAL   <= rf_rs2;
         slot_rs1  <= rs1_idx;
         slot_rs2  <= rs2_idx;
      end else begin
         if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
         end
         if (WB_WE && (slot_rs1 != 5'd0) && (WB_RD == slot_rs1)) begin
            RS1_VAL <= WB_VAL;
         end
         if (WB_WE && (slot_rs2 != 5'd0) && (WB_RD == slot_rs2)) begin
            RS2_VAL <= WB_VAL;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, hand-written
// stall/flush/reset sequences, then randomized traffic against a model.
module tb_decode_stage;
   import def::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, wb_we, out_valid, out_ready;
   logic [31:0] in_instr, wb_val, rs1_val, rs2_val;
   logic [4:0]  wb_rd;
   control_info ctr_info;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_INSTR(in_instr), .FLUSH(flush), .WB_WE(wb_we), .WB_RD(wb_rd),
      .WB_VAL(wb_val), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .CTR_INFO(ctr_info), .RS1_VAL(rs1_val), .RS2_VAL(rs2_val)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wval);
      in_valid  = v;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      wb_we     = we;
      wb_rd     = wrd;
      wb_val    = wval;
   endtask

   // one-hot order: add sub and or xor sll srl sra slt sltu (bit 9 .. bit 0)
   function automatic control_info mk(input logic [9:0] oh, input bit isimm, input logic [4:0] rd,
                                      input logic [31:0] imm, input bit ill);
      control_info c;
      c = '0;
      {c.add, c.sub, c.and_, c.or_, c.xor_, c.sll, c.srl, c.sra, c.slt, c.sltu} = oh;
      c.is_imm  = isimm;
      c.rd      = rd;
      c.rd_we   = (rd != 5'd0) && !ill;
      c.imm     = imm;
      c.illegal = ill;
      return c;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         f7_care;
      int         op;
   } rule_t;
   rule_t rules[$];

   function automatic void add_rule(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                    input bit care, input int op);
      rule_t r;
      r.opc = opc; r.f3 = f3; r.f7 = f7; r.f7_care = care; r.op = op;
      rules.push_back(r);
   endfunction

   function automatic control_info ref_decode(input logic [31:0] w);
      int          hit;
      int          s;
      logic [31:0] imm;
      hit = -1;
      foreach (rules[i]) begin
         if (rules[i].opc == w[6:0] && rules[i].f3 == w[14:12] &&
             (!rules[i].f7_care || rules[i].f7 == w[31:25])) hit = rules[i].op;
      end
      if (hit < 0) return mk(10'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      if (w[6:0] == 7'h33) return mk(10'd1 << (9 - hit), 1'b0, w[11:7], 32'd0, 1'b0);
      if (hit >= 5 && hit <= 7) imm = 32'(w[24:20]);
      else begin
         s = int'(w[31:20]);
         if (s >= 2048) s = s - 4096;
         imm = 32'(s);
      end
      return mk(10'd1 << (9 - hit), 1'b1, w[11:7], imm, 1'b0);
   endfunction

   logic [31:0] mreg [32];
   bit          mvalid;
   control_info mctr;
   logic [31:0] m1, m2;
   logic [4:0]  mi1, mi2;

   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_we && wb_rd == idx) return wb_val;
      return mreg[idx];
   endfunction

   // advance the model by one edge using the inputs currently applied
   task automatic model_step();
      bit acc;
      if (rst) begin
         foreach (mreg[i]) mreg[i] = 32'd0;
         mvalid = 0; mctr = '0; m1 = 32'd0; m2 = 32'd0; mi1 = 5'd0; mi2 = 5'd0;
         return;
      end
      acc = in_valid && (!mvalid || out_ready);
      if (flush) mvalid = 0;
      else if (acc) begin
         mctr   = ref_decode(in_instr);
         mvalid = 1;
         mi1 = mctr.illegal ? 5'd0 : in_instr[19:15];
         mi2 = (mctr.illegal || mctr.is_imm) ? 5'd0 : in_instr[24:20];
         m1  = rf_read(mi1);
         m2  = rf_read(mi2);
      end else begin
         if (mvalid && out_ready) mvalid = 0;
         if (wb_we && mi1 != 5'd0 && wb_rd == mi1) m1 = wb_val;
         if (wb_we && mi2 != 5'd0 && wb_rd == mi2) m2 = wb_val;
      end
      if (wb_we && wb_rd != 5'd0) mreg[wb_rd] = wb_val;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [31:0] instr;
      logic [9:0]  oh;
      bit          isimm;
      logic [4:0]  rd;
      logic [31:0] imm;
      bit          ill;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;
   vec_t vecs[11];

   initial begin
      control_info exp_c;
      logic [31:0] w;

      // OP rules, then OP-IMM rules (op: 0 add .. 9 sltu)
      add_rule(7'h33, 3'd0, 7'h00, 1, 0); add_rule(7'h33, 3'd0, 7'h20, 1, 1);
      add_rule(7'h33, 3'd7, 7'h00, 1, 2); add_rule(7'h33, 3'd6, 7'h00, 1, 3);
      add_rule(7'h33, 3'd4, 7'h00, 1, 4); add_rule(7'h33, 3'd1, 7'h00, 1, 5);
      add_rule(7'h33, 3'd5, 7'h00, 1, 6); add_rule(7'h33, 3'd5, 7'h20, 1, 7);
      add_rule(7'h33, 3'd2, 7'h00, 1, 8); add_rule(7'h33, 3'd3, 7'h00, 1, 9);
      add_rule(7'h13, 3'd0, 7'h00, 0, 0); add_rule(7'h13, 3'd7, 7'h00, 0, 2);
      add_rule(7'h13, 3'd6, 7'h00, 0, 3); add_rule(7'h13, 3'd4, 7'h00, 0, 4);
      add_rule(7'h13, 3'd1, 7'h00, 1, 5); add_rule(7'h13, 3'd5, 7'h00, 1, 6);
      add_rule(7'h13, 3'd5, 7'h20, 1, 7); add_rule(7'h13, 3'd2, 7'h00, 0, 8);
      add_rule(7'h13, 3'd3, 7'h00, 0, 9);

      // registers assumed: x1=5, x2=3
      vecs[0]  = '{32'h002081B3, 10'b1000000000, 0, 5'd3, 32'd0, 0, 32'd5, 32'd3};
      vecs[1]  = '{32'h402081B3, 10'b0100000000, 0, 5'd3, 32'd0, 0, 32'd5, 32'd3};
      vecs[2]  = '{32'h0020F1B3, 10'b0010000000, 0, 5'd3, 32'd0, 0, 32'd5, 32'd3};
      vecs[3]  = '{32'h00500093, 10'b1000000000, 1, 5'd1, 32'd5, 0, 32'd0, 32'd0};
      vecs[4]  = '{32'hFFF0C113, 10'b0000100000, 1, 5'd2, 32'hFFFFFFFF, 0, 32'd5, 32'd0};
      vecs[5]  = '{32'h4030D293, 10'b0000000100, 1, 5'd5, 32'd3, 0, 32'd5, 32'd0};
      vecs[6]  = '{32'h0020B033, 10'b0000000001, 0, 5'd0, 32'd0, 0, 32'd5, 32'd3};
      vecs[7]  = '{32'hFFFFFFFF, 10'b0000000000, 0, 5'd0, 32'd0, 1, 32'd0, 32'd0};
      vecs[8]  = '{32'h01F11213, 10'b0000010000, 1, 5'd4, 32'd31, 0, 32'd3, 32'd0};
      vecs[9]  = '{32'h0000A083, 10'b0000000000, 0, 5'd0, 32'd0, 1, 32'd0, 32'd0};
      vecs[10] = '{32'h40209033, 10'b0000000000, 0, 5'd0, 32'd0, 1, 32'd0, 32'd0};

      // reset state
      rst = 1'b1;
      set_in(0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
      repeat (2) step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_ctr_info", ctr_info, 64'd0);
      chk("rst_rs1", rs1_val, 32'd0);
      chk("rst_rs2", rs2_val, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      // load x1=5, x2=3
      set_in(0, 32'd0, 1, 0, 1, 5'd1, 32'd5); step();
      set_in(0, 32'd0, 1, 0, 1, 5'd2, 32'd3); step();

      // back-to-back table, with a write to x0 every cycle
      foreach (vecs[i]) begin
         set_in(1, vecs[i].instr, 1, 0, 1, 5'd0, 32'd7);
         #1;
         chk("tbl_in_ready", in_ready, 1'b1);
         step();
         exp_c = mk(vecs[i].oh, vecs[i].isimm, vecs[i].rd, vecs[i].imm, vecs[i].ill);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, 1'b1);
         chk($sformatf("tbl%0d_ctr", i), ctr_info, exp_c);
         if (!vecs[i].ill) begin
            chk($sformatf("tbl%0d_rs1", i), rs1_val, vecs[i].e1);
            chk($sformatf("tbl%0d_rs2", i), rs2_val, vecs[i].e2);
         end
      end
      set_in(0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
      step();
      chk("drain_out_valid", out_valid, 1'b0);

      // stall with snooped writeback of x2
      set_in(1, 32'h402081B3, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("stall_loaded", out_valid, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         set_in(1, 32'h002081B3, 0, 0, c == 2, 5'd2, 32'd9);
         #1;
         chk($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
         step();
      end
      set_in(0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
      #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_ctr", ctr_info, mk(10'b0100000000, 0, 5'd3, 32'd0, 0));
      chk("stall_rs1", rs1_val, 32'd5);
      chk("stall_rs2", rs2_val, 32'd9);
      step();
      chk("stall_consumed", out_valid, 1'b0);

      // flush beats a same-cycle accept; same-cycle writeback still lands
      set_in(1, 32'h002081B3, 0, 0, 0, 5'd0, 32'd0);
      step();
      set_in(1, 32'h402081B3, 1, 1, 1, 5'd6, 32'h1234);
      #1;
      chk("flush_in_ready", in_ready, 1'b1);
      step();
      chk("flush_out_valid", out_valid, 1'b0);
      set_in(1, 32'h000303B3, 1, 0, 0, 5'd0, 32'd0);
      step();
      chk("postflush_ctr", ctr_info, mk(10'b1000000000, 0, 5'd7, 32'd0, 0));
      chk("postflush_rs1", rs1_val, 32'h1234);

      // reset during a stall
      set_in(0, 32'd0, 1, 0, 0, 5'd0, 32'd0); step();
      set_in(1, 32'h002081B3, 0, 0, 0, 5'd0, 32'd0); step();
      chk("prerst_rs1", rs1_val, 32'd5);
      rst = 1'b1;
      set_in(0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
      step();
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_ctr", ctr_info, 64'd0);
      chk("midrst_rs1", rs1_val, 32'd0);
      chk("midrst_rs2", rs2_val, 32'd0);
      set_in(1, 32'h002081B3, 1, 0, 0, 5'd0, 32'd0);
      #1;
      chk("midrst_in_ready", in_ready, 1'b1);
      step();
      chk("midrst_x1", rs1_val, 32'd0);
      chk("midrst_x2", rs2_val, 32'd0);

      // randomized traffic against the model
      rst = 1'b1;
      set_in(0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
      model_step();
      step();
      for (int n = 0; n < 3000; n++) begin
         w = $urandom;
         case ($urandom_range(0, 3))
            0: begin w[6:0] = 7'h33; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            1: begin w[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            2: w[6:0] = 7'h13;
            default: ;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            w[24:20] = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
         end
         rst = ($urandom_range(0, 199) == 0);
         set_in($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
         #1;
         chk("rnd_in_ready", in_ready, !mvalid || out_ready);
         model_step();
         step();
         chk("rnd_out_valid", out_valid, mvalid);
         if (mvalid) begin
            chk("rnd_ctr", ctr_info, mctr);
            if (!mctr.illegal) begin
               chk("rnd_rs1", rs1_val, m1);
               chk("rnd_rs2", rs2_val, m2);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
